piso_shift_register_param: RTL and testbench
============================================

PISO_SHIFT_REGISTER_PARAM -- requirements
Module: piso_shift_register_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, parallel word width; legal range 2..64.
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = bit [DATA_WIDTH-1] first, 0 = bit [0] first.
REQ-003 SHALL have port Clk_In  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port Resetb_In  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port Data_Valid_In  input  1  source presents a word on Parallel_Data_In.
REQ-006 SHALL have port Parallel_Data_In  input  DATA_WIDTH  word to serialise.
REQ-007 SHALL have port Shift_Enable_In  input  1  advance one serial bit when high; hold when low.
REQ-008 SHALL have port Data_Ready_Out  output  1  block accepts a word this cycle.
REQ-009 SHALL have port Serial_Data_Out  output  1  current serial bit.
REQ-010 SHALL have port Serial_Valid_Out  output  1  Serial_Data_Out carries a frame bit.
REQ-011 SHALL have port Frame_Start_Out  output  1  high with the first bit of a frame.
REQ-012 SHALL have port Frame_Done_Out  output  1  high with the last bit of a frame.
REQ-013 SHALL have port Busy_Out  output  1  high while in SHIFT state.

Function
REQ-014 SHALL implement a two-state FSM: IDLE, SHIFT.
REQ-015 Accept = rising edge with Data_Valid_In=1 and Data_Ready_Out=1; word captured into internal shift register, bit counter cleared, state -> SHIFT.
REQ-016 Data_Ready_Out SHALL be 1 in IDLE, and in SHIFT only while the last frame bit is presented with Shift_Enable_In=1 (combinational); otherwise 0.
REQ-017 First bit SHALL appear on Serial_Data_Out the cycle after accept (latency 1), with Serial_Valid_Out=1 and Frame_Start_Out=1.
REQ-018 Each edge in SHIFT with Shift_Enable_In=1 SHALL advance one bit; with Shift_Enable_In=0, all outputs and state hold.
REQ-019 Frame length L SHALL be DATA_WIDTH bits (DATA_WIDTH+1 with parity, REQ-030).
REQ-020 Frame_Done_Out SHALL be 1 while bit L is presented; on the edge leaving it, state -> IDLE unless a new word is accepted on that edge, in which case state stays SHIFT and the new frame's first bit follows with no gap.
REQ-021 In IDLE, Serial_Data_Out, Serial_Valid_Out, Frame_Start_Out, Frame_Done_Out, Busy_Out SHALL be 0; Shift_Enable_In ignored.
REQ-022 Data_Valid_In while Data_Ready_Out=0 SHALL be ignored; no word overwrites a frame in progress.
REQ-023 Bit counter SHALL be sized ceil(log2(DATA_WIDTH+2)) and never wrap within a frame.

Reset
REQ-024 Resetb_In=0 SHALL immediately (asynchronously) force state IDLE, shift register and counter 0, all outputs 0 except Data_Ready_Out, which is 1 once Resetb_In=1.
REQ-025 Reset mid-frame SHALL abort the frame; no further bits of that word are emitted.
REQ-026 Reset release SHALL take effect synchronously; first accept possible on the first edge after release.

Configuration
REQ-027 Macro PISO_PARITY_EN SHALL select an appended even-parity bit.
REQ-028 Without PISO_PARITY_EN: L = DATA_WIDTH; no parity logic present.
REQ-029 With PISO_PARITY_EN: L = DATA_WIDTH+1; parity = XOR of captured word, computed at accept.
REQ-030 With PISO_PARITY_EN: parity bit SHALL be presented after the data bits and carries Frame_Done_Out; MSB_FIRST does not affect its position.

Verification (DATA_WIDTH=8 unless stated)
REQ-031 MSB_FIRST=1, accept 8'hA5, enable held 1 -> bits 1,0,1,0,0,1,0,1 on cycles 1..8 after accept; Frame_Start on cycle 1, Frame_Done on cycle 8, IDLE on cycle 9.
REQ-032 MSB_FIRST=0, accept 8'h01 -> bits 1,0,0,0,0,0,0,0; Busy_Out high for exactly 8 cycles.
REQ-033 Back-to-back 8'hFF then 8'h00, Data_Valid_In held -> 16 contiguous valid bits (8 ones, 8 zeros), Data_Ready_Out high only on cycle 8 of frame 1, Frame_Start on bits 1 and 9.
REQ-034 Accept 8'hC3, Shift_Enable_In low for 3 cycles after bit 2 -> bit 2 held 4 cycles, frame spans 11 cycles, sequence 1,1,0,0,0,0,1,1.
REQ-035 Assert Resetb_In low during bit 4 of 8'hFF -> outputs 0 same cycle, no further bits; after release, accepting 8'h80 emits 1 then seven 0s.
REQ-036 PISO_PARITY_EN defined, accept 8'h07 -> 9 bits 0,0,0,0,0,1,1,1,1; Frame_Done on bit 9; 8'h03 gives parity bit 0.

Source files
------------

// File: rtl/piso_shift_register_param.sv
// piso_shift_register_param
// Parallel-in / serial-out shift register with a valid/ready word interface.
// A word is accepted on a rising edge when Data_Valid_In and Data_Ready_Out
// are both high; its bits are then presented one per enabled clock, first bit
// on the cycle after accept, MSB or LSB first depending on MSB_FIRST.
// The next word can be accepted while the last bit of the current frame is
// being shifted out, so back-to-back frames run without a gap.
//
// Optional build macro: PISO_PARITY_EN appends an even-parity bit (XOR of the
// captured word) after the data bits; frame length becomes DATA_WIDTH+1.
//
// Parameters:
//   DATA_WIDTH  parallel word width (2..64)
//   MSB_FIRST   1: bit [DATA_WIDTH-1] first, 0: bit [0] first
// Ports:
//   Clk_In            clock, rising edge
//   Resetb_In         asynchronous active-low reset
//   Data_Valid_In     source presents a word
//   Parallel_Data_In  word to serialise
//   Shift_Enable_In   advance one serial bit when high, hold when low
//   Data_Ready_Out    block accepts a word this cycle (combinational)
//   Serial_Data_Out   current serial bit
//   Serial_Valid_Out  Serial_Data_Out carries a frame bit
//   Frame_Start_Out   first bit of a frame
//   Frame_Done_Out    last bit of a frame
//   Busy_Out          high while shifting a frame
module piso_shift_register_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MSB_FIRST  = 1
) (
    input  logic                  Clk_In,
    input  logic                  Resetb_In,
    input  logic                  Data_Valid_In,
    input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
    input  logic                  Shift_Enable_In,
    output logic                  Data_Ready_Out,
    output logic                  Serial_Data_Out,
    output logic                  Serial_Valid_Out,
    output logic                  Frame_Start_Out,
    output logic                  Frame_Done_Out,
    output logic                  Busy_Out
);

`ifdef PISO_PARITY_EN
    localparam int unsigned FRAME_LEN = DATA_WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = DATA_WIDTH;
`endif
    localparam int unsigned      CNT_W    = $clog2(DATA_WIDTH + 2);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                r_state;
    // Bits not yet presented, pre-shifted so the next bit sits at the exit end
    logic [DATA_WIDTH-1:0] r_shift;
    // Index of the bit currently presented within the frame
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_serial;
    logic                  r_valid;
    logic                  r_start;
    logic                  r_done;
    logic                  r_busy;
`ifdef PISO_PARITY_EN
    logic                  r_parity;
`endif

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_first_bit;
    logic                  w_next_bit;
    logic [DATA_WIDTH-1:0] w_load_shift;
    logic [DATA_WIDTH-1:0] w_adv_shift;
    logic [CNT_W-1:0]      w_cnt_inc;

    // Handshake, bit selection and shift-register next values
    always_comb begin
        w_ready   = Resetb_In & ((r_state == S_IDLE) | (r_done & Shift_Enable_In));
        w_accept  = w_ready & Data_Valid_In;
        w_cnt_inc = r_cnt + CNT_W'(1);
        if (MSB_FIRST != 0) begin
            w_first_bit  = Parallel_Data_In[DATA_WIDTH-1];
            w_load_shift = Parallel_Data_In << 1;
            w_next_bit   = r_shift[DATA_WIDTH-1];
            w_adv_shift  = r_shift << 1;
        end else begin
            w_first_bit  = Parallel_Data_In[0];
            w_load_shift = Parallel_Data_In >> 1;
            w_next_bit   = r_shift[0];
            w_adv_shift  = r_shift >> 1;
        end
`ifdef PISO_PARITY_EN
        // Parity follows the last data bit regardless of bit order
        if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
            w_next_bit = r_parity;
        end
`endif
    end

    assign Data_Ready_Out   = w_ready;
    assign Serial_Data_Out  = r_serial;
    assign Serial_Valid_Out = r_valid;
    assign Frame_Start_Out  = r_start;
    assign Frame_Done_Out   = r_done;
    assign Busy_Out         = r_busy;

    // Frame FSM with registered outputs
    always_ff @(posedge Clk_In or negedge Resetb_In) begin
        if (!Resetb_In) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_serial <= 1'b0;
            r_valid  <= 1'b0;
            r_start  <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
`ifdef PISO_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else if (w_accept) begin
            // New word: present its first bit on the next cycle
            r_state  <= S_SHIFT;
            r_shift  <= w_load_shift;
            r_cnt    <= '0;
            r_serial <= w_first_bit;
            r_valid  <= 1'b1;
            r_start  <= 1'b1;
            r_done   <= 1'b0;
            r_busy   <= 1'b1;
`ifdef PISO_PARITY_EN
            r_parity <= ^Parallel_Data_In;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_IDLE;
                end
                S_SHIFT: begin
                    if (Shift_Enable_In) begin
                        if (r_done) begin
                            r_state  <= S_IDLE;
                            r_serial <= 1'b0;
                            r_valid  <= 1'b0;
                            r_start  <= 1'b0;
                            r_done   <= 1'b0;
                            r_busy   <= 1'b0;
                        end else begin
                            r_cnt    <= w_cnt_inc;
                            r_shift  <= w_adv_shift;
                            r_serial <= w_next_bit;
                            r_start  <= 1'b0;
                            r_done   <= (w_cnt_inc == LAST_IDX);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_shift_register_param.sv
// Bench for piso_shift_register_param: an MSB-first and an LSB-first instance
// share stimulus; a frame-level model (list of frame bits + bits remaining)
// predicts ready and the output bundle every cycle.
module tb_piso_shift_register_param;

    localparam int unsigned DW = 8;
`ifdef PISO_PARITY_EN
    localparam int L = DW + 1;
`else
    localparam int L = DW;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          dv    = 1'b0;
    logic          en    = 1'b0;
    logic [DW-1:0] pd    = '0;

    wire [1:0] rdy, sd, sv, fs, fd, bz;

    piso_shift_register_param #(.DATA_WIDTH(DW), .MSB_FIRST(1)) dut_msb (
        .Clk_In(clk), .Resetb_In(rst_n), .Data_Valid_In(dv),
        .Parallel_Data_In(pd), .Shift_Enable_In(en),
        .Data_Ready_Out(rdy[0]), .Serial_Data_Out(sd[0]), .Serial_Valid_Out(sv[0]),
        .Frame_Start_Out(fs[0]), .Frame_Done_Out(fd[0]), .Busy_Out(bz[0])
    );

    piso_shift_register_param #(.DATA_WIDTH(DW), .MSB_FIRST(0)) dut_lsb (
        .Clk_In(clk), .Resetb_In(rst_n), .Data_Valid_In(dv),
        .Parallel_Data_In(pd), .Shift_Enable_In(en),
        .Data_Ready_Out(rdy[1]), .Serial_Data_Out(sd[1]), .Serial_Valid_Out(sv[1]),
        .Frame_Start_Out(fs[1]), .Frame_Done_Out(fd[1]), .Busy_Out(bz[1])
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: frame bits in presentation order (index 0 first) and bits left
    logic [L-1:0] m_frame [2];
    int           m_left  [2];
    logic [1:0]   exp_rdy;
    logic [1:0]   got_rdy;
    logic [1:0]   last_bit;

    function automatic logic [L-1:0] make_frame(input logic [DW-1:0] w, input bit msb);
        logic [L-1:0] f;
        f = '0;
        for (int i = 0; i < int'(DW); i++) f[i] = msb ? w[int'(DW) - 1 - i] : w[i];
`ifdef PISO_PARITY_EN
        f[L-1] = ^w;
`endif
        return f;
    endfunction

    // {valid, data, start, done, busy}
    function automatic logic [4:0] exp_vec(input int k);
        int idx;
        if (m_left[k] == 0) return 5'b0;
        idx = L - m_left[k];
        return {1'b1, m_frame[k][idx], m_left[k] == L, m_left[k] == 1, 1'b1};
    endfunction

    function automatic logic [4:0] obs_vec(input int k);
        return {sv[k], sd[k], fs[k], fd[k], bz[k]};
    endfunction

    // One clock: drive inputs at negedge, sample ready, advance the model at posedge
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic e);
        @(negedge clk);
        dv = v; pd = d; en = e;
        #1;
        for (int k = 0; k < 2; k++)
            exp_rdy[k] = rst_n && (m_left[k] == 0 || (m_left[k] == 1 && e));
        got_rdy = rdy;
        @(posedge clk);
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (m_left[k] > 0 && e) m_left[k]--;
                if (exp_rdy[k] && v) begin
                    m_frame[k] = make_frame(d, k == 0);
                    m_left[k]  = L;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dv = 1'b0; en = 1'b0; pd = '0;
        m_left[0] = 0; m_left[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({rdy[k], obs_vec(k)} !== 6'b0) begin
                errors++;
                $display("FAIL reset_hold dut%0d: got %b exp %b", k, {rdy[k], obs_vec(k)}, 6'b0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({rdy[k], obs_vec(k)} !== 6'b100000) begin
                errors++;
                $display("FAIL reset_release dut%0d: got %b exp %b", k, {rdy[k], obs_vec(k)}, 6'b100000);
            end
        end
    endtask

    task automatic test_single_frame(input logic [DW-1:0] w, input string tag);
        logic [DW-1:0] col [2];
        int            busy_cnt [2];
        col[0] = '0; col[1] = '0; busy_cnt[0] = 0; busy_cnt[1] = 0;
        for (int c = 1; c <= L + 1; c++) begin
            drive(c == 1, w, 1'b1);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got_rdy[k] !== exp_rdy[k] || obs_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL %s dut%0d cyc %0d: rdy/out got %b/%b exp %b/%b",
                             tag, k, c, got_rdy[k], obs_vec(k), exp_rdy[k], exp_vec(k));
                end
                if (bz[k]) busy_cnt[k]++;
            end
            if (c <= int'(DW)) begin
                col[0][int'(DW) - c] = sd[0];
                col[1][c - 1]        = sd[1];
            end
            if (c == L) last_bit = sd;
            if (c == 1) begin
                checks++;
                if (fs !== 2'b11) begin
                    errors++;
                    $display("FAIL %s frame_start: got %b exp 11", tag, fs);
                end
            end
            if (c == L) begin
                checks++;
                if (fd !== 2'b11) begin
                    errors++;
                    $display("FAIL %s frame_done: got %b exp 11", tag, fd);
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (col[k] !== w) begin
                errors++;
                $display("FAIL %s word dut%0d: got %h exp %h", tag, k, col[k], w);
            end
            checks++;
            if (busy_cnt[k] != L) begin
                errors++;
                $display("FAIL %s busy_cycles dut%0d: got %0d exp %0d", tag, k, busy_cnt[k], L);
            end
        end
    endtask

    task automatic test_back_to_back();
        int rdy_hi = 0;
        int vcnt   = 0;
        int ones   = 0;
        for (int c = 1; c <= 2 * L + 1; c++) begin
            drive(c <= L + 1, (c == 1) ? 8'hFF : 8'h00, 1'b1);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got_rdy[k] !== exp_rdy[k] || obs_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL b2b dut%0d cyc %0d: rdy/out got %b/%b exp %b/%b",
                             k, c, got_rdy[k], obs_vec(k), exp_rdy[k], exp_vec(k));
                end
            end
            if (c >= 2 && c <= L + 1 && got_rdy[0]) rdy_hi++;
            if (c <= 2 * L && sv[0]) vcnt++;
            if (sv[0] && sd[0]) ones++;
            if (c == 1 || c == L + 1) begin
                checks++;
                if (fs[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b frame_start cyc %0d: got %b exp 1", c, fs[0]);
                end
            end
        end
        checks++;
        if (rdy_hi != 1) begin
            errors++;
            $display("FAIL b2b ready_in_frame1: got %0d exp 1", rdy_hi);
        end
        checks++;
        if (vcnt != 2 * L) begin
            errors++;
            $display("FAIL b2b valid_bits: got %0d exp %0d", vcnt, 2 * L);
        end
        checks++;
        if (ones != int'(DW)) begin
            errors++;
            $display("FAIL b2b ones: got %0d exp %0d", ones, DW);
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] col [2];
        int            vcnt = 0;
        int            j    = 0;
        logic          e;
        col[0] = '0; col[1] = '0;
        for (int c = 1; c <= L + 4; c++) begin
            e = !(c >= 3 && c <= 5);
            drive(c == 1, 8'hC3, e);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got_rdy[k] !== exp_rdy[k] || obs_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL stall dut%0d cyc %0d: rdy/out got %b/%b exp %b/%b",
                             k, c, got_rdy[k], obs_vec(k), exp_rdy[k], exp_vec(k));
                end
            end
            if (sv[0]) vcnt++;
            if (e && sv[0] && j < int'(DW)) begin
                col[0][int'(DW) - 1 - j] = sd[0];
                col[1][j]                = sd[1];
                j++;
            end
            if (!e) begin
                checks++;
                if ({sv, sd} !== 4'b1111) begin
                    errors++;
                    $display("FAIL stall hold cyc %0d: valid/data got %b exp 1111", c, {sv, sd});
                end
            end
        end
        checks++;
        if (vcnt != L + 3) begin
            errors++;
            $display("FAIL stall span: got %0d exp %0d", vcnt, L + 3);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (col[k] !== 8'hC3) begin
                errors++;
                $display("FAIL stall word dut%0d: got %h exp c3", k, col[k]);
            end
        end
    endtask

`ifdef PISO_PARITY_EN
    task automatic test_parity();
        test_single_frame(8'h07, "par07");
        checks++;
        if (last_bit !== 2'b11) begin
            errors++;
            $display("FAIL parity07: got %b exp 11", last_bit);
        end
        test_single_frame(8'h03, "par03");
        checks++;
        if (last_bit !== 2'b00) begin
            errors++;
            $display("FAIL parity03: got %b exp 00", last_bit);
        end
    endtask
`endif

    task automatic test_reset_mid();
        drive(1'b1, 8'hFF, 1'b1);
        repeat (3) drive(1'b0, 8'h00, 1'b1);
        checks++;
        if (sv[0] !== 1'b1 || m_left[0] != L - 3) begin
            errors++;
            $display("FAIL reset_mid pre: valid got %b exp 1", sv[0]);
        end
        #2;
        rst_n = 1'b0;
        m_left[0] = 0; m_left[1] = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({rdy[k], obs_vec(k)} !== 6'b0) begin
                errors++;
                $display("FAIL reset_mid async dut%0d: got %b exp %b", k, {rdy[k], obs_vec(k)}, 6'b0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            drive(1'b0, 8'h00, 1'b1);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_vec(k) !== 5'b0) begin
                    errors++;
                    $display("FAIL reset_mid no_bits dut%0d: got %b exp 00000", k, obs_vec(k));
                end
            end
        end
        test_single_frame(8'h80, "after_reset");
    endtask

    task automatic test_random();
        logic          v;
        logic          e;
        logic [DW-1:0] d;
        for (int c = 0; c < 400; c++) begin
            v = ($urandom_range(0, 2) != 0);
            e = ($urandom_range(0, 3) != 0);
            d = DW'($urandom());
            drive(v, d, e);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got_rdy[k] !== exp_rdy[k] || obs_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL random dut%0d cyc %0d: rdy/out got %b/%b exp %b/%b",
                             k, c, got_rdy[k], obs_vec(k), exp_rdy[k], exp_vec(k));
                end
            end
        end
    endtask

    initial begin
        m_left[0] = 0; m_left[1] = 0;
        m_frame[0] = '0; m_frame[1] = '0;
        exp_rdy = '0; got_rdy = '0; last_bit = '0;
        #2;
        test_reset();
        test_single_frame(8'hA5, "a5");
        test_single_frame(8'h01, "x01");
        test_back_to_back();
        test_stall();
`ifdef PISO_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
